rom_bus_sequencer: RTL and testbench

//  Bus-side sequencer for the i4001 ROM: tracks the 8-phase instruction cycle
//  (A1 A2 A3 M1 M2 X1 X2 X3) from sync and assembles the 8-bit address from
//  the nibbles on d_in. It decodes chip select at A3 and then drives the

---
 rtl/rom_bus_sequencer.sv | 108 ++++++++++
 tb/tb_rom_bus_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_sequencer.sv
// Bus-side sequencer for the i4001 ROM: follows the 8-phase instruction
// cycle, assembles the fetch address and drives the ROM byte in M1/M2.
module rom_bus_sequencer #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic       cm_rom,
    input  logic [3:0] d_in,
    input  logic [7:0] rom_data,
    output logic [7:0] addr,
    output logic [3:0] d_out,
    output logic       d_oe,
    output logic [2:0] phase,
    output logic       active,
    output logic       fetch_done
);

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } phase_e;

    phase_e     state_q, state_d;
    logic       active_q, active_d;
    logic [7:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic       drive;

    // Phase, lock, address and chip-select registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= A1;
            active_q <= 1'b0;
            addr_q   <= 8'h00;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
        end
    end

    // Next phase and per-phase captures; a resync always restarts at A1
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        if (!active_q) begin
            if (sync) begin
                active_d = 1'b1;
                state_d  = A1;
            end
        end else begin
            unique case (state_q)
                A1: begin
                    addr_d[3:0] = d_in;
                    state_d     = A2;
                end
                A2: begin
                    addr_d[7:4] = d_in;
                    state_d     = A3;
                end
                A3: begin
                    sel_d   = cm_rom && (d_in == CHIP_ID);
                    state_d = M1;
                end
                M1: state_d = M2;
                M2: state_d = X1;
                X1: state_d = X2;
                X2: state_d = X3;
                X3: begin
                    sel_d   = 1'b0;
                    state_d = A1;
                end
            endcase
            if (sync) begin
                state_d = A1;
                sel_d   = 1'b0;
            end
        end
    end

    // Bus outputs decoded from registered state only
    always_comb begin
        drive = sel_q && (state_q == M1 || state_q == M2);
        d_out = 4'h0;
        if (drive) begin
            d_out = (state_q == M1) ? rom_data[7:4] : rom_data[3:0];
        end
    end

    assign d_oe       = drive;
    assign fetch_done = sel_q && (state_q == X1);
    assign addr       = addr_q;
    assign phase      = state_q;
    assign active     = active_q;

endmodule

// File: tb/tb_rom_bus_sequencer.sv
// Scoreboard bench for rom_bus_sequencer: directed bus cycles followed by
// randomized traffic checked against a cycle-position reference model.
module tb_rom_bus_sequencer;

    localparam logic [3:0] CHIP = 4'h3;

    logic       clk;
    logic       rst_n;
    logic       sync;
    logic       cm_rom;
    logic [3:0] d_in;
    logic [7:0] rom_data;
    logic [7:0] addr;
    logic [3:0] d_out;
    logic       d_oe;
    logic [2:0] phase;
    logic       active;
    logic       fetch_done;

    typedef struct {
        logic [2:0] ph;
        logic       act;
        logic [7:0] ad;
        logic       oe;
        logic [3:0] dq;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // reference model: position in the 8-slot cycle, -1 when not locked
    int         m_pos;
    logic [7:0] m_addr;
    bit         m_sel;

    rom_bus_sequencer #(.CHIP_ID(CHIP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync(sync),
        .cm_rom(cm_rom),
        .d_in(d_in),
        .rom_data(rom_data),
        .addr(addr),
        .d_out(d_out),
        .d_oe(d_oe),
        .phase(phase),
        .active(active),
        .fetch_done(fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_out(input logic [7:0] rd);
        exp_t e;
        bit   m1;
        bit   m2;
        m1    = (m_pos == 3);
        m2    = (m_pos == 4);
        e.ph  = (m_pos < 0) ? 3'd0 : 3'(m_pos);
        e.act = (m_pos >= 0);
        e.ad  = m_addr;
        e.oe  = m_sel && (m1 || m2);
        e.dq  = !e.oe ? 4'h0 : (m1 ? rd[7:4] : rd[3:0]);
        e.fd  = m_sel && (m_pos == 5);
        return e;
    endfunction

    task automatic model_edge(input bit s, input bit cm, input logic [3:0] di);
        bit nsel;
        if (m_pos < 0) begin
            if (s) m_pos = 0;
            return;
        end
        nsel = m_sel;
        if (m_pos == 0) m_addr[3:0] = di;
        if (m_pos == 1) m_addr[7:4] = di;
        if (m_pos == 2) nsel = cm && (di == CHIP);
        if (m_pos == 7) nsel = 0;
        m_pos = (m_pos + 1) % 8;
        if (s) begin
            m_pos = 0;
            nsel  = 0;
        end
        m_sel = nsel;
    endtask

    // one bus cycle: drive inputs just after the edge, queue the expectation
    task automatic cycle(input bit rst, input bit s, input bit cm,
                         input logic [3:0] di, input logic [7:0] rd);
        @(posedge clk);
        #1;
        rst_n    = rst;
        sync     = s;
        cm_rom   = cm;
        d_in     = di;
        rom_data = rd;
        if (!rst) begin
            m_pos  = -1;
            m_addr = 8'h00;
            m_sel  = 0;
        end
        exp_q.push_back(model_out(rd));
        if (rst) model_edge(s, cm, di);
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    // monitor: the bus is time-slotted, so every cycle presents an output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase", 8'(phase), 8'(e.ph));
                chk("active", 8'(active), 8'(e.act));
                chk("addr", addr, e.ad);
                chk("d_oe", 8'(d_oe), 8'(e.oe));
                chk("d_out", 8'(d_out), 8'(e.dq));
                chk("fetch_done", 8'(fetch_done), 8'(e.fd));
            end
        end
    end

    // full bus cycle starting from A1 with given nibbles
    task automatic bus_cycle(input logic [3:0] lo, input logic [3:0] hi,
                             input logic [3:0] chip, input bit cm,
                             input logic [7:0] rd);
        cycle(1, 0, 0, lo, rd);
        cycle(1, 0, 0, hi, rd);
        cycle(1, 0, cm, chip, rd);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 4'h0, rd);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_pos    = -1;
        m_addr   = 8'h00;
        m_sel    = 0;
        rst_n    = 1'b0;
        sync     = 1'b0;
        cm_rom   = 1'b0;
        d_in     = 4'h0;
        rom_data = 8'h00;

        cycle(0, 0, 0, 4'h0, 8'h00);
        cycle(0, 1, 0, 4'h0, 8'h00);
        cycle(1, 0, 0, 4'h0, 8'h00);
        cycle(1, 0, 0, 4'h0, 8'h00);

        // selected fetch, then free-running second cycle
        cycle(1, 1, 0, 4'h0, 8'hC7);
        bus_cycle(4'hA, 4'h5, 4'h3, 1, 8'hC7);
        bus_cycle(4'h1, 4'hF, 4'h3, 1, 8'h9E);
        // wrong chip, then cm_rom low
        bus_cycle(4'hA, 4'h5, 4'h4, 1, 8'hC7);
        bus_cycle(4'h2, 4'h6, 4'h3, 0, 8'h3B);

        // resync in M1
        cycle(1, 0, 0, 4'h4, 8'h5D);
        cycle(1, 0, 0, 4'h8, 8'h5D);
        cycle(1, 0, 1, 4'h3, 8'h5D);
        cycle(1, 1, 0, 4'h0, 8'h5D);
        bus_cycle(4'h7, 4'h2, 4'h3, 1, 8'hE1);

        // reset asserted in the middle of M1
        cycle(1, 0, 0, 4'hB, 8'h66);
        cycle(1, 0, 0, 4'hC, 8'h66);
        cycle(1, 0, 1, 4'h3, 8'h66);
        cycle(0, 0, 0, 4'h0, 8'h66);
        cycle(0, 0, 0, 4'h0, 8'h66);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 4'h3, 8'hFF);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] di;
            di = (m_pos == 2 && $urandom_range(0, 1) == 1) ? CHIP
                                                         : 4'($urandom);
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0,
                  di, 8'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
